// File: rtl/i2c_slave_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile_if
// Purpose  : Pad-side I2C lines and local register-file port of the
//            i2c_slave_regfile responder, bundled with slave/master modports.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_slave_regfile_if #(
  parameter int REG_AW = 3
);
  logic              scl_pad_i;
  logic              sda_pad_i;
  logic              sda_pad_o;
  logic              sda_padoen_o;
  logic [REG_AW-1:0] reg_adr_i;
  logic [7:0]        reg_dat_o;
  logic              wr_stb_o;
  logic [REG_AW-1:0] wr_adr_o;
  logic [7:0]        wr_dat_o;
  logic              busy_o;

  modport slave (
    input  scl_pad_i, sda_pad_i, reg_adr_i,
    output sda_pad_o, sda_padoen_o, reg_dat_o, wr_stb_o, wr_adr_o, wr_dat_o, busy_o
  );

  modport master (
    output scl_pad_i, sda_pad_i, reg_adr_i,
    input  sda_pad_o, sda_padoen_o, reg_dat_o, wr_stb_o, wr_adr_o, wr_dat_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Purpose  : I2C slave with an auto-incrementing 8-bit register file and local
//            write strobes. Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a
//            3-sample majority-free (all-agree) filter on SCL/SDA.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         REG_AW   = 3
) (
  input  logic               wb_clk_i,
  input  logic               arst_i,
  i2c_slave_regfile_if.slave bus
);

  localparam int                c_DEPTH   = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] c_PTR_ONE = REG_AW'(1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_scl_sync, r_sda_sync;
  logic              w_scl, w_sda;
  logic              r_scl_d, r_sda_d;
  logic              w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [REG_AW-1:0] r_ptr;
  logic [7:0]        r_regs [c_DEPTH];
  logic              r_sda_oe_n, r_ack_seen, r_rw, r_busy;
  logic              r_wr_stb;
  logic [REG_AW-1:0] r_wr_adr;
  logic [7:0]        r_wr_dat;
  logic [7:0]        w_byte, w_rd_byte;
  logic              w_oe_n_nxt, w_ack_seen_nxt, w_rw_nxt, w_busy_nxt;
  logic              w_cnt_clr, w_cnt_en, w_shift_in, w_shift_out, w_load_rd;
  logic              w_ptr_load, w_ptr_inc, w_wr_en;

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.scl_pad_i};
      r_sda_sync <= {r_sda_sync[0], bus.sda_pad_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  // Filtered line moves only when the two held samples and the newest agree.
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_filt, r_sda_filt;

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      if ({r_scl_hist, r_scl_sync[1]} == 3'b111)      r_scl_filt <= 1'b1;
      else if ({r_scl_hist, r_scl_sync[1]} == 3'b000) r_scl_filt <= 1'b0;
      if ({r_sda_hist, r_sda_sync[1]} == 3'b111)      r_sda_filt <= 1'b1;
      else if ({r_sda_hist, r_sda_sync[1]} == 3'b000) r_sda_filt <= 1'b0;
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_rd_byte  = r_regs[r_ptr];

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // START/STOP are checked first so they win over a data sample in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_oe_n_nxt     = r_sda_oe_n;
    w_ack_seen_nxt = r_ack_seen;
    w_rw_nxt       = r_rw;
    w_busy_nxt     = r_busy;
    w_cnt_clr      = 1'b0;
    w_cnt_en       = 1'b0;
    w_shift_in     = 1'b0;
    w_shift_out    = 1'b0;
    w_load_rd      = 1'b0;
    w_ptr_load     = 1'b0;
    w_ptr_inc      = 1'b0;
    w_wr_en        = 1'b0;
    if (w_start) begin
      w_state_nxt    = ST_ADDR;
      w_cnt_clr      = 1'b1;
      w_oe_n_nxt     = 1'b1;
      w_ack_seen_nxt = 1'b0;
      w_busy_nxt     = 1'b1;
    end else if (w_stop) begin
      w_state_nxt    = ST_IDLE;
      w_cnt_clr      = 1'b1;
      w_oe_n_nxt     = 1'b1;
      w_ack_seen_nxt = 1'b0;
      w_busy_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_cnt_en   = 1'b1;
            w_shift_in = 1'b1;
            if (r_bit_cnt == 3'd7) begin
              if (r_state == ST_ADDR) begin
                if (w_byte[7:1] == SLV_ADDR) begin
                  w_state_nxt = ST_ADDR_ACK;
                  w_rw_nxt    = w_byte[0];
                end else begin
                  w_state_nxt = ST_IGNORE;
                end
              end else if (r_state == ST_PTR) begin
                w_ptr_load  = 1'b1;
                w_state_nxt = ST_PTR_ACK;
              end else begin
                w_wr_en     = 1'b1;
                w_ptr_inc   = 1'b1;
                w_state_nxt = ST_WDATA_ACK;
              end
            end
          end
        end
        // First SCL fall pulls SDA, the rise marks the ACK sampled, next fall moves on.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_rise) begin
            w_ack_seen_nxt = 1'b1;
          end else if (w_scl_fall) begin
            if (!r_ack_seen) begin
              w_oe_n_nxt = 1'b0;
            end else begin
              w_ack_seen_nxt = 1'b0;
              w_oe_n_nxt     = 1'b1;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                w_state_nxt = ST_RDATA;
                w_load_rd   = 1'b1;
                w_oe_n_nxt  = w_rd_byte[7];
              end else if (r_state == ST_ADDR_ACK) begin
                w_state_nxt = ST_PTR;
              end else begin
                w_state_nxt = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_en = 1'b1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = ST_RDATA_ACK;
              w_ptr_inc   = 1'b1;
            end
          end else if (w_scl_fall) begin
            w_shift_out = 1'b1;
            w_oe_n_nxt  = r_shift[6];
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) w_ack_seen_nxt = 1'b1;
            else        w_state_nxt    = ST_IGNORE;
          end else if (w_scl_fall) begin
            if (!r_ack_seen) begin
              w_oe_n_nxt = 1'b1;
            end else begin
              w_ack_seen_nxt = 1'b0;
              w_state_nxt    = ST_RDATA;
              w_load_rd      = 1'b1;
              w_oe_n_nxt     = w_rd_byte[7];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_sda_oe_n <= 1'b1;
      r_ack_seen <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_wr_adr   <= '0;
      r_wr_dat   <= '0;
    end else begin
      r_sda_oe_n <= w_oe_n_nxt;
      r_ack_seen <= w_ack_seen_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_stb   <= w_wr_en;
      if (w_cnt_clr)     r_bit_cnt <= '0;
      else if (w_cnt_en) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_load_rd)        r_shift <= w_rd_byte;
      else if (w_shift_in)  r_shift <= w_byte;
      else if (w_shift_out) r_shift <= {r_shift[6:0], 1'b0};
      if (w_ptr_load)     r_ptr <= w_byte[REG_AW-1:0];
      else if (w_ptr_inc) r_ptr <= r_ptr + c_PTR_ONE;
      if (w_wr_en) begin
        r_wr_adr <= r_ptr;
        r_wr_dat <= w_byte;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < c_DEPTH; i++) r_regs[i] <= 8'h00;
    end else if (w_wr_en) begin
      r_regs[r_ptr] <= w_byte;
    end
  end

  assign bus.sda_pad_o    = 1'b0;
  assign bus.sda_padoen_o = r_sda_oe_n;
  assign bus.reg_dat_o    = r_regs[bus.reg_adr_i];
  assign bus.wr_stb_o     = r_wr_stb;
  assign bus.wr_adr_o     = r_wr_adr;
  assign bus.wr_dat_o     = r_wr_dat;
  assign bus.busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Purpose  : Bit-banged I2C master driving i2c_slave_regfile, scoreboard checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;
  localparam int H = 10;

  typedef struct packed {logic kind; logic [7:0] val;} item_t;
  typedef struct packed {logic [2:0] adr; logic [7:0] dat;} wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic [2:0] rd_adr;
  logic       miss_win = 1'b0;
  logic       miss_drove = 1'b0;
  logic [7:0] g_exp;
  logic       g_ack;
  int         n_cmp = 0;
  int         n_err = 0;
  item_t      exp_q[$];
  item_t      obs_q[$];
  wr_t        exp_wr_q[$];

  i2c_slave_regfile_if #(.REG_AW(3)) bus();

  assign bus.scl_pad_i = scl_m;
  assign bus.sda_pad_i = sda_m & bus.sda_padoen_o;
  assign bus.reg_adr_i = rd_adr;

  i2c_slave_regfile #(.SLV_ADDR(7'h50), .REG_AW(3)) dut (
    .wb_clk_i (clk),
    .arst_i   (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic item_t mk(input logic kind, input logic [7:0] val);
    item_t it;
    it.kind = kind;
    it.val  = val;
    return it;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_bit(input logic b, input logic glitch);
    scl_m = 1'b0; tick(4); sda_m = b; tick(6); scl_m = 1'b1;
    if (glitch) begin
      tick(4); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(4);
    end else begin
      tick(H);
    end
  endtask

  task automatic get_bit(output logic b);
    scl_m = 1'b0; tick(4); sda_m = 1'b1; tick(6); scl_m = 1'b1; tick(5);
    b = bus.sda_pad_i;
    tick(5);
  endtask

  task automatic start_cond(input logic repeated);
    if (repeated) begin
      scl_m = 1'b0; tick(4); sda_m = 1'b1; tick(6); scl_m = 1'b1; tick(H);
    end
    sda_m = 1'b0; tick(H);
  endtask

  task automatic stop_cond();
    scl_m = 1'b0; tick(4); sda_m = 1'b0; tick(6); scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input int glitch_bit);
    logic a;
    exp_q.push_back(mk(1'b0, {7'd0, exp_ack}));
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
    get_bit(a);
    obs_q.push_back(mk(1'b0, {7'd0, a}));
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic m_ack);
    logic [7:0] d;
    logic       b;
    exp_q.push_back(mk(1'b1, exp));
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(!m_ack, 1'b0);
    obs_q.push_back(mk(1'b1, d));
  endtask

  // Slave-driven bits seen by the master are matched in order against expectations.
  initial forever begin
    item_t o, e;
    @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_%s: got %0h, expected nothing", o.kind ? "rdata" : "ack", o.val);
      end else begin
        e = exp_q.pop_front();
        if (e !== o) begin
          n_err++;
          $display("FAIL %s: got %0h, expected %0h", e.kind ? "rdata" : "ack", o.val, e.val);
        end
      end
    end
  end

  initial forever begin
    wr_t w, e;
    @(negedge clk);
    if (bus.wr_stb_o === 1'b1) begin
      w.adr = bus.wr_adr_o;
      w.dat = bus.wr_dat_o;
      n_cmp++;
      if (exp_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_wr_stb: got adr=%0h dat=%0h, expected none", w.adr, w.dat);
      end else begin
        e = exp_wr_q.pop_front();
        if (e !== w) begin
          n_err++;
          $display("FAIL wr_stb: got adr=%0h dat=%0h, expected adr=%0h dat=%0h",
                   w.adr, w.dat, e.adr, e.dat);
        end
      end
    end
  end

  always @(negedge clk) if (miss_win && !bus.sda_padoen_o) miss_drove <= 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_adr = 3'd0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_sda_padoen", {31'd0, bus.sda_padoen_o}, 1);
    check("rst_sda_pad_o",  {31'd0, bus.sda_pad_o}, 0);
    check("rst_wr_stb",     {31'd0, bus.wr_stb_o}, 0);
    check("rst_wr_adr",     {29'd0, bus.wr_adr_o}, 0);
    check("rst_wr_dat",     {24'd0, bus.wr_dat_o}, 0);
    check("rst_busy",       {31'd0, bus.busy_o}, 0);
    for (int i = 0; i < 8; i++) begin
      rd_adr = 3'(i); #1;
      check("rst_reg", {24'd0, bus.reg_dat_o}, 0);
    end

    // Write burst: ptr 2, data 0x11, 0x22
    exp_wr_q.push_back({3'd2, 8'h11});
    exp_wr_q.push_back({3'd3, 8'h22});
    start_cond(1'b0);
    check("busy_after_start", {31'd0, bus.busy_o}, 1);
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h02, 1'b0, -1);
    send_byte(8'h11, 1'b0, -1);
    send_byte(8'h22, 1'b0, -1);
    stop_cond();
    check("busy_after_stop", {31'd0, bus.busy_o}, 0);
    rd_adr = 3'd2; #1; check("reg2", {24'd0, bus.reg_dat_o}, 32'h11);
    rd_adr = 3'd3; #1; check("reg3", {24'd0, bus.reg_dat_o}, 32'h22);

    // Preload reg7/reg0 through the wrap, then read them back across the wrap
    exp_wr_q.push_back({3'd7, 8'h5A});
    exp_wr_q.push_back({3'd0, 8'hC3});
    start_cond(1'b0);
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h07, 1'b0, -1);
    send_byte(8'h5A, 1'b0, -1);
    send_byte(8'hC3, 1'b0, -1);
    stop_cond();
    start_cond(1'b0);
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h07, 1'b0, -1);
    start_cond(1'b1);
    send_byte(8'hA1, 1'b0, -1);
    recv_byte(8'h5A, 1'b1);
    recv_byte(8'hC3, 1'b0);
    check("sda_release_after_nack", {31'd0, bus.sda_padoen_o}, 1);
    stop_cond();
    // ptr should now be 1: reg1 is still 0x00
    start_cond(1'b0);
    send_byte(8'hA1, 1'b0, -1);
    recv_byte(8'h00, 1'b0);
    stop_cond();

    // Address miss
    miss_win = 1'b1;
    start_cond(1'b0);
    send_byte(8'hA2, 1'b1, -1);
    send_byte(8'h55, 1'b1, -1);
    stop_cond();
    miss_win = 1'b0;
    tick(1);
    check("miss_sda_never_driven", {31'd0, miss_drove}, 0);

    // STOP mid-byte
    exp_wr_q.push_back({3'd5, 8'h77});
    start_cond(1'b0);
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h05, 1'b0, -1);
    send_byte(8'h77, 1'b0, -1);
    stop_cond();
    start_cond(1'b0);
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h05, 1'b0, -1);
    put_bit(1'b1, 1'b0); put_bit(1'b0, 1'b0); put_bit(1'b1, 1'b0); put_bit(1'b1, 1'b0);
    stop_cond();
    check("busy_after_partial", {31'd0, bus.busy_o}, 0);
    rd_adr = 3'd5; #1; check("reg5_unchanged", {24'd0, bus.reg_dat_o}, 32'h77);

    // SCL glitch on bit 4 of data 0x11 written to reg4
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    g_exp = 8'h11; g_ack = 1'b0;
`else
    g_exp = 8'h18; g_ack = 1'b1;
`endif
    exp_wr_q.push_back({3'd4, g_exp});
    start_cond(1'b0);
    send_byte(8'hA0, 1'b0, -1);
    send_byte(8'h04, 1'b0, -1);
    send_byte(8'h11, g_ack, 4);
    stop_cond();
    rd_adr = 3'd4; #1; check("reg4_glitch", {24'd0, bus.reg_dat_o}, {24'd0, g_exp});

    // Reset while driving a 0 data bit (ptr=5, reg5=0x77)
    start_cond(1'b0);
    send_byte(8'hA1, 1'b0, -1);
    scl_m = 1'b0; tick(10);
    check("sda_driven_before_reset", {31'd0, bus.sda_padoen_o}, 0);
    scl_m = 1'b1; tick(3);
    #2 rst = 1'b1;
    #1 check("sda_release_on_reset", {31'd0, bus.sda_padoen_o}, 1);
    tick(3);
    rst = 1'b0;
    tick(2);
    check("busy_after_reset", {31'd0, bus.busy_o}, 0);
    for (int i = 0; i < 8; i++) begin
      rd_adr = 3'(i); #1;
      check("reg_after_reset", {24'd0, bus.reg_dat_o}, 0);
    end

    tick(20);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_wr_q_drained", exp_wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
